// File: rtl/gf16_inv_ti_stage2.sv
// gf16_inv_ti_stage2: TI glitch-barrier register for four GF(2^4) shares, then mask refresh and compression to three shares
module gf16_inv_ti_stage2 #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic             ClkxCI,
  input  logic             RstxRI,
  input  logic             FlushxSI,
  input  logic             InValidxSI,
  output logic             InReadyxSO,
  input  logic [W-1:0]     XxDI0,
  input  logic [W-1:0]     XxDI1,
  input  logic [W-1:0]     XxDI2,
  input  logic [W-1:0]     XxDI3,
  input  logic             RndValidxSI,
  output logic             RndReadyxSO,
  input  logic [W-1:0]     RndxDI,
  output logic             OutValidxSO,
  input  logic             OutReadyxSI,
  output logic [W-1:0]     QxDO0,
  output logic [W-1:0]     QxDO1,
  output logic [W-1:0]     QxDO2,
  output logic [CNT_W-1:0] CntxDO
);
  logic [W-1:0]     r_a0, r_a1, r_a2, r_a3;
  logic [W-1:0]     r_q0, r_q1, r_q2;
  logic             r_avalid, r_ovalid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_advb, w_cap, w_xfer;
  // Handshakes depend only on state and valid/ready lines, never on share data.
  assign w_advb      = !FlushxSI & r_avalid & RndValidxSI & (!r_ovalid | OutReadyxSI);
  assign InReadyxSO  = !FlushxSI & (!r_avalid | w_advb);
  assign RndReadyxSO = w_advb;
  assign w_cap       = InValidxSI & InReadyxSO;
  assign w_xfer      = !FlushxSI & r_ovalid & OutReadyxSI;
  assign OutValidxSO = r_ovalid;
  assign QxDO0       = r_q0;
  assign QxDO1       = r_q1;
  assign QxDO2       = r_q2;
  assign CntxDO      = r_cnt;
  always_ff @(posedge ClkxCI or posedge RstxRI)
    if (RstxRI) begin
      r_avalid <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      r_avalid <= !FlushxSI & (w_cap | (r_avalid & !w_advb));
      r_ovalid <= !FlushxSI & (w_advb | (r_ovalid & !OutReadyxSI));
    end
  // Share registers load only on their enables so idle cycles cause no toggling.
  always_ff @(posedge ClkxCI or posedge RstxRI)
    if (RstxRI) begin
      r_a0 <= '0;
      r_a1 <= '0;
      r_a2 <= '0;
      r_a3 <= '0;
    end else if (w_cap) begin
      r_a0 <= XxDI0;
      r_a1 <= XxDI1;
      r_a2 <= XxDI2;
      r_a3 <= XxDI3;
    end
  always_ff @(posedge ClkxCI or posedge RstxRI)
    if (RstxRI) begin
      r_q0 <= '0;
      r_q1 <= '0;
      r_q2 <= '0;
    end else if (w_advb) begin
      r_q0 <= r_a0 ^ RndxDI;
      r_q1 <= r_a1 ^ r_a3;
      r_q2 <= r_a2 ^ RndxDI;
    end
  always_ff @(posedge ClkxCI or posedge RstxRI)
    if (RstxRI) r_cnt <= '0;
    else if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
endmodule

// File: tb/tb_gf16_inv_ti_stage2.sv
// tb_gf16_inv_ti_stage2: directed stimulus with a capture/mask scoreboard checked by an output monitor
module tb_gf16_inv_ti_stage2;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, rnd_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, rnd_ready, out_valid;
  logic [3:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0, rnd = '0, tgt = '0;
  logic [3:0] q0, q1, q2;
  logic [15:0] cnt;

  gf16_inv_ti_stage2 dut (
    .ClkxCI(clk), .RstxRI(rst), .FlushxSI(flush),
    .InValidxSI(in_valid), .InReadyxSO(in_ready),
    .XxDI0(x0), .XxDI1(x1), .XxDI2(x2), .XxDI3(x3),
    .RndValidxSI(rnd_valid), .RndReadyxSO(rnd_ready), .RndxDI(rnd),
    .OutValidxSO(out_valid), .OutReadyxSI(out_ready),
    .QxDO0(q0), .QxDO1(q1), .QxDO2(q2), .CntxDO(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] a0, a1, a2, a3, t;} item_t;
  item_t capq[$];
  logic [3:0] rq[$];
  item_t it;
  logic [3:0] r, e0, e1, e2;
  logic [15:0] exp_cnt = '0;
  int checks = 0, errors = 0, n_cap = 0, n_out = 0, rnd_seq = 0;
  bit took = 0, auto_rnd = 1;
  logic [3:0] inv_t [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                             4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

  // Monitor: checks output transfers against captured shares paired with consumed masks.
  always @(negedge clk) begin
    if (rst || flush) begin
      capq.delete();
      rq.delete();
      if (rst) begin exp_cnt = '0; n_out = 0; n_cap = 0; end
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (capq.size() == 0 || rq.size() == 0) begin
          errors++;
          $display("FAIL spurious_out got q=%h,%h,%h with no result outstanding", q0, q1, q2);
        end else begin
          it = capq.pop_front();
          r = rq.pop_front();
          e0 = it.a0 ^ r; e1 = it.a1 ^ it.a3; e2 = it.a2 ^ r;
          if ({q0, q1, q2} !== {e0, e1, e2}) begin
            errors++;
            $display("FAIL q_shares got %h,%h,%h exp %h,%h,%h", q0, q1, q2, e0, e1, e2);
          end
          checks++;
          if ((q0 ^ q1 ^ q2) !== it.t) begin
            errors++;
            $display("FAIL q_xor got %h exp %h", q0 ^ q1 ^ q2, it.t);
          end
        end
        checks++;
        if (cnt !== exp_cnt) begin
          errors++;
          $display("FAIL cnt_at_xfer got %h exp %h", cnt, exp_cnt);
        end
        exp_cnt++;
        n_out++;
      end
      if (in_valid && in_ready) begin capq.push_back('{x0, x1, x2, x3, tgt}); n_cap++; end
      if (rnd_valid && rnd_ready) begin rq.push_back(rnd); took = 1; end
    end
  end

  always begin
    @(posedge clk); #1;
    if (took) begin
      took = 0;
      if (auto_rnd) begin rnd_seq++; rnd = 4'(rnd_seq * 7 + 3); end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] a0, a1, a2, a3, t);
    int n = 0;
    bit acc = 0;
    x0 = a0; x1 = a1; x2 = a2; x3 = a3; tgt = t; in_valid = 1;
    do begin #1; acc = in_ready; @(posedge clk); #1; n++; end while (!acc && n < 50);
    in_valid = 0;
    if (!acc) begin checks++; errors++; $display("FAIL send_timeout got no accept exp accept within 50 cycles"); end
  endtask

  task automatic drain();
    int n = 0;
    while (capq.size() > 0 && n < 200) begin tick(); n++; end
    chk("drain_empty", capq.size(), 0);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    chk("rst_ovalid", out_valid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_q", {q0, q1, q2}, 0);
    chk("rst_rnd_ready", rnd_ready, 0);
    rst = 0;
    tick();
    // Test 1: hand-computed vector
    auto_rnd = 0; rnd = 4'h6; rnd_valid = 1; out_ready = 1;
    send(4'h3, 4'h5, 4'h0, 4'hA, 4'hC);
    chk("lat_not_yet", out_valid, 0);
    tick();
    chk("t1_ovalid", out_valid, 1);
    chk("t1_q", {q0, q1, q2}, 12'h5F6);
    chk("t1_cnt0", cnt, 0);
    tick();
    chk("t1_cnt1", cnt, 1);
    chk("t1_ovalid_clr", out_valid, 0);
    // Test 2: sweep of all 16 elements, shares of the inverse
    auto_rnd = 1; took = 1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a0, a1, a2;
      a0 = 4'(i); a1 = 4'(i * 5 + 1); a2 = 4'(i * 3 + 7);
      send(a0, a1, a2, inv_t[i] ^ a0 ^ a1 ^ a2, inv_t[i]);
    end
    drain();
    chk("t2_cnt", cnt, 17);
    // Test 3: output stall with back-to-back inputs
    auto_rnd = 0; rnd = 4'h9; out_ready = 0;
    send(4'h1, 4'h2, 4'h4, 4'h8, 4'hF);
    send(4'h3, 4'h3, 4'h3, 4'h3, 4'h0);
    x0 = 4'hA; x1 = 4'hB; x2 = 4'hC; x3 = 4'hD; tgt = 4'h0; in_valid = 1;
    repeat (5) begin
      tick();
      chk("t3_in_ready", in_ready, 0);
      chk("t3_ovalid", out_valid, 1);
      chk("t3_q_held", {q0, q1, q2}, 12'h8AD);
    end
    out_ready = 1;
    send(4'hA, 4'hB, 4'hC, 4'hD, 4'h0);
    drain();
    chk("t3_cnt", cnt, 20);
    // Test 4: mask starvation
    rnd_valid = 0;
    send(4'h7, 4'h3, 4'hC, 4'h1, 4'h9);
    repeat (3) begin
      tick();
      chk("t4_rnd_ready", rnd_ready, 0);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_ovalid", out_valid, 0);
    end
    rnd = 4'h5; rnd_valid = 1;
    tick();
    chk("t4_q", {q0, q1, q2}, 12'h229);
    drain();
    // Test 5: flush with both stages full
    auto_rnd = 1; out_ready = 0;
    send(4'h1, 4'h1, 4'h1, 4'h1, 4'h0);
    send(4'h2, 4'h4, 4'h6, 4'h8, 4'h8);
    tick();
    chk("t5_full", {out_valid, in_ready}, 2'b10);
    x0 = 4'hF; x1 = 4'hF; x2 = 4'hF; x3 = 4'hF; tgt = 4'h0; in_valid = 1; flush = 1;
    #1;
    chk("t5_flush_in_ready", in_ready, 0);
    chk("t5_flush_rnd_ready", rnd_ready, 0);
    tick();
    flush = 0; in_valid = 0;
    #1;
    chk("t5_ovalid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_cnt", cnt, exp_cnt);
    out_ready = 1;
    repeat (3) tick();
    chk("t5_no_out", out_valid, 0);
    // Test 6a: async reset mid-stream
    x0 = 4'h6; x1 = 4'h2; x2 = 4'h9; x3 = 4'h1; tgt = 4'hC; in_valid = 1;
    repeat (3) tick();
    #2 rst = 1;
    #1;
    chk("t6_rst_ovalid", out_valid, 0);
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_q", {q0, q1, q2}, 0);
    chk("t6_rst_rnd_ready", rnd_ready, 0);
    in_valid = 0;
    tick();
    rst = 0;
    tick();
    // Test 6b: counter wrap
    x0 = 4'h1; x1 = 4'h2; x2 = 4'h3; x3 = 4'h4; tgt = 4'h4; in_valid = 1;
    n = 0;
    while (n_cap < 65535 && n < 70000) begin tick(); n++; end
    in_valid = 0;
    chk("t6_caps", n_cap, 65535);
    drain();
    chk("t6_cnt_max", cnt, 16'hFFFF);
    send(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    drain();
    chk("t6_cnt_wrap", cnt, 0);
    chk("end_rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
